game_flow_ctrl: RTL and testbench
=================================

# game_flow_ctrl

Game-flow controller that produces the UI status consumed by the screen-drawing logic: game state, task, key count, life count and stage-unlock mask. It hit-tests mouse clicks against the on-screen button regions for the current state, sequences title, stage, success, fail and staff screens, and tracks in-stage events (key pickup, door entry, damage). It sits between the mouse and gameplay logic and the pixel-address and UI-overlay renderer.

## Interface
- INVULN_CYCLES, 50_000_000: damage-immunity window after a hit, in clk cycles; must be ≥1.
- clk  in  1  system clock; one clock domain.
- rst  in  1  synchronous, active-high reset.
- mouse_x  in  10  cursor column, 640-pixel space.
- mouse_y  in  10  cursor row, 480-pixel space.
- click  in  1  one-cycle pulse on left-button press.
- key_pick  in  1  one-cycle pulse: player touched a key.
- door_enter  in  1  one-cycle pulse: player reached the door.
- damage  in  1  one-cycle pulse: player was hit.
- state  out  4  TITLE=0, STAFF=1, STAGE1=2, SUCCESS1=3, STAGE2=4, SUCCESS2=5, STAGE3=6, SUCCESS3=7, FAIL=8.
- todo  out  2  NONE=0, FIND_KEY=1, FIND_DOOR=3; value 2 is never driven.
- key_find  out  2  keys collected, 0..3.
- heart  out  2  lives remaining, 0..3.
- play_valid  out  4  stage-unlock mask. Bit n is set when stage n is selectable. Bit 0 is always 0 and bit 1 is always 1.

## Operation
- Hit-test coordinates: hx = mouse_x>>1 and hy = mouse_y>>1. A button matches only when 120 ≤ hx < 200.
- TITLE buttons:
  - hy 120..139 = STAGE1.
  - hy 160..179 = STAGE2, only if play_valid[2].
  - hy 200..219 = STAGE3, only if play_valid[3].
  - A click on a locked stage button is ignored.
- SUCCESS1 and SUCCESS2 buttons: hy 140..159 = NEXT; hy 180..199 = BACK.
- SUCCESS3 button: hy 140..159 = NEXT only.
- FAIL buttons: hy 140..159 = RETRY; hy 180..199 = BACK.
- STAFF: a click anywhere moves to TITLE.
- Transitions on a matching click:
  - STAGEn button moves to STAGEn.
  - NEXT from SUCCESS1 moves to STAGE2; from SUCCESS2 to STAGE3; from SUCCESS3 to STAFF.
  - BACK moves to TITLE.
  - RETRY moves to the stage held in internal register last_stage.
- On every entry to a STAGEn state:
  - key_find=0, heart=3, todo=FIND_KEY.
  - Invulnerability counter cleared.
  - last_stage=n.
- In-stage events; these are ignored in all non-stage states, and clicks are ignored in stage states:
  - key_pick while key_find<3: key_find+1. When the result is 3, todo becomes FIND_DOOR in the same update. key_pick at 3 is ignored.
  - door_enter while todo==FIND_DOOR: state moves to SUCCESSn. door_enter while todo==FIND_KEY is ignored.
  - damage while the invulnerability counter is 0: heart−1 and the counter loads INVULN_CYCLES−1. If heart was 1, heart becomes 0 and state moves to FAIL. damage while the counter is nonzero is ignored.
  - The counter decrements to 0 and saturates there.
- Unlocking:
  - Entering SUCCESS1 sets play_valid[2]; entering SUCCESS2 sets play_valid[3].
  - Bits are never cleared except by rst.
- todo is NONE in every non-stage state.
- Simultaneous events:
  - door_enter plus damage in the same cycle: door_enter wins. State moves to SUCCESSn and heart is unchanged.
  - key_pick plus damage: both apply.
  - key_pick completing the third key plus door_enter in the same cycle: door_enter is ignored, because todo was FIND_KEY before the update.

## Timing
- Reset values: state=TITLE, todo=NONE, key_find=0, heart=3, play_valid=4'b0010, last_stage=STAGE1, counter=0.
- All outputs are registered; there is no combinational path from inputs to outputs.
- An input pulse at edge N is reflected on the outputs after edge N (1-cycle latency). Successive pulses on consecutive cycles are each processed.
- The hit test uses mouse_x and mouse_y sampled in the same cycle as click.
- rst during any state, including mid-stage or mid-invulnerability, restores all reset values on the next edge.

## Configuration
- GAME_UNLOCK_ALL_EN defined:
  - play_valid resets to 4'b1110 and all stage buttons on TITLE are always selectable.
  - The success-driven unlock is redundant; the bits stay set.
- GAME_UNLOCK_ALL_EN undefined: behaviour as specified above.

## Structure
- Shared package game_pkg, used by this block and the renderer:
  - state codes;
  - todo codes;
  - button-code enum: BTN_NONE, BTN_STAGE1, BTN_STAGE2, BTN_STAGE3, BTN_NEXT, BTN_BACK, BTN_RETRY, BTN_ANY;
  - button region bounds in the 320×240 space.
- Sub-module ui_hit_test: combinational. Takes (state, hx, hy, play_valid) and returns a button code.
- This block holds:
  - the FSM;
  - the key, heart and unlock registers;
  - last_stage;
  - the invulnerability counter.

## Test plan
- **Stage1 to SUCCESS1:** rst, then click at (320,260) → state=2, heart=3, todo=1. Then 3×key_pick → key_find=3, todo=3. Then door_enter → state=3, play_valid=4'b0110.
- **Locked stage and unlock:** from reset, click at (320,340) on TITLE → state stays 0. After completing stage1 and clicking BACK at (320,380) → state=0; the same click now gives state=4.
- **Damage and invulnerability:** INVULN_CYCLES=4, in STAGE1. Damage pulses at cycles 0, 2, 4, 8, 12 → heart takes the values 2, 2, 1, 0, with state=8 after the pulse at cycle 8; the pulse at cycle 12 is ignored. Then RETRY at (320,300) → state=2, heart=3.
- **Simultaneous events:** todo=FIND_DOOR and heart=1, door_enter and damage in the same cycle → state=SUCCESSn, heart=1.
- **Full progression:** SUCCESS3 NEXT at (320,300) → state=1. A click anywhere → state=0.
- **Reset mid-stage and macro:** rst in STAGE2 with key_find=2 → all reset values. With GAME_UNLOCK_ALL_EN, play_valid=4'b1110 after rst, and a click at (320,420) → state=6.

Source files
------------

// File: rtl/game_pkg.sv
// Shared game definitions: state/todo/button codes, button regions in the
// 320x240 hit-test space, and small state helpers used by control and render.
package game_pkg;

  typedef enum logic [3:0] {
    ST_TITLE    = 4'd0,
    ST_STAFF    = 4'd1,
    ST_STAGE1   = 4'd2,
    ST_SUCCESS1 = 4'd3,
    ST_STAGE2   = 4'd4,
    ST_SUCCESS2 = 4'd5,
    ST_STAGE3   = 4'd6,
    ST_SUCCESS3 = 4'd7,
    ST_FAIL     = 4'd8
  } state_t;

  typedef enum logic [1:0] {
    TODO_NONE      = 2'd0,
    TODO_FIND_KEY  = 2'd1,
    TODO_FIND_DOOR = 2'd3
  } todo_t;

  typedef enum logic [2:0] {
    BTN_NONE,
    BTN_STAGE1,
    BTN_STAGE2,
    BTN_STAGE3,
    BTN_NEXT,
    BTN_BACK,
    BTN_RETRY,
    BTN_ANY
  } btn_t;

  // Every button shares one column; rows are given by their top edge.
  localparam logic [8:0] BTN_X_LO     = 9'd120;
  localparam logic [8:0] BTN_X_HI     = 9'd200;
  localparam logic [8:0] BTN_H        = 9'd20;
  localparam logic [8:0] TITLE_S1_Y   = 9'd120;
  localparam logic [8:0] TITLE_S2_Y   = 9'd160;
  localparam logic [8:0] TITLE_S3_Y   = 9'd200;
  localparam logic [8:0] MENU_UPPER_Y = 9'd140;
  localparam logic [8:0] MENU_LOWER_Y = 9'd180;

  function automatic logic is_stage(input state_t s);
    return (s == ST_STAGE1) || (s == ST_STAGE2) || (s == ST_STAGE3);
  endfunction

  function automatic state_t success_of(input state_t s);
    case (s)
      ST_STAGE1: return ST_SUCCESS1;
      ST_STAGE2: return ST_SUCCESS2;
      ST_STAGE3: return ST_SUCCESS3;
      default:   return ST_TITLE;
    endcase
  endfunction

  function automatic state_t next_of(input state_t s);
    case (s)
      ST_SUCCESS1: return ST_STAGE2;
      ST_SUCCESS2: return ST_STAGE3;
      ST_SUCCESS3: return ST_STAFF;
      default:     return ST_TITLE;
    endcase
  endfunction

endpackage

// File: rtl/ui_hit_test.sv
// Combinational button hit test: maps the half-resolution cursor position to
// the button code valid for the current screen.
module ui_hit_test
  import game_pkg::*;
(
  input  state_t     state,
  input  logic [8:0] hx,
  input  logic [8:0] hy,
  input  logic [3:0] play_valid,
  output btn_t       btn
);

  logic       in_col;
  btn_t       stage_btn;
  logic [1:0] stage_idx;

  function automatic logic in_row(input logic [8:0] y, input logic [8:0] top);
    return (y >= top) && (y < top + BTN_H);
  endfunction

  // Title buttons are filtered through the unlock mask; index 0 is never set.
  always_comb begin
    in_col    = (hx >= BTN_X_LO) && (hx < BTN_X_HI);
    stage_btn = BTN_NONE;
    stage_idx = 2'd0;
    btn       = BTN_NONE;

    if (in_row(hy, TITLE_S1_Y)) begin
      stage_btn = BTN_STAGE1;
      stage_idx = 2'd1;
    end else if (in_row(hy, TITLE_S2_Y)) begin
      stage_btn = BTN_STAGE2;
      stage_idx = 2'd2;
    end else if (in_row(hy, TITLE_S3_Y)) begin
      stage_btn = BTN_STAGE3;
      stage_idx = 2'd3;
    end

    case (state)
      ST_TITLE: begin
        if (in_col && play_valid[stage_idx]) btn = stage_btn;
      end
      ST_SUCCESS1, ST_SUCCESS2: begin
        if (in_col && in_row(hy, MENU_UPPER_Y))      btn = BTN_NEXT;
        else if (in_col && in_row(hy, MENU_LOWER_Y)) btn = BTN_BACK;
      end
      ST_SUCCESS3: begin
        if (in_col && in_row(hy, MENU_UPPER_Y)) btn = BTN_NEXT;
      end
      ST_FAIL: begin
        if (in_col && in_row(hy, MENU_UPPER_Y))      btn = BTN_RETRY;
        else if (in_col && in_row(hy, MENU_LOWER_Y)) btn = BTN_BACK;
      end
      ST_STAFF: btn = BTN_ANY;
      default:  btn = BTN_NONE;
    endcase
  end

endmodule

// File: rtl/game_flow_ctrl.sv
// Game-flow controller: screen sequencing, in-stage key/door/damage tracking
// and the stage-unlock mask. GAME_UNLOCK_ALL_EN makes every stage selectable.
module game_flow_ctrl
  import game_pkg::*;
#(
  parameter int INVULN_CYCLES = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] mouse_x,
  input  logic [9:0] mouse_y,
  input  logic       click,
  input  logic       key_pick,
  input  logic       door_enter,
  input  logic       damage,
  output logic [3:0] state,
  output logic [1:0] todo,
  output logic [1:0] key_find,
  output logic [1:0] heart,
  output logic [3:0] play_valid
);

  localparam int CNT_W = (INVULN_CYCLES > 1) ? $clog2(INVULN_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(INVULN_CYCLES - 1);

`ifdef GAME_UNLOCK_ALL_EN
  localparam logic [3:0] PV_RESET = 4'b1110;
`else
  localparam logic [3:0] PV_RESET = 4'b0010;
`endif

  state_t           state_q, state_d, last_q, last_d;
  todo_t            todo_q, todo_d;
  logic [1:0]       key_q, key_d, heart_q, heart_d;
  logic [3:0]       pv_q, pv_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [8:0]       hx, hy;
  btn_t             btn;

  assign hx = 9'(mouse_x >> 1);
  assign hy = 9'(mouse_y >> 1);

  ui_hit_test u_hit (
    .state      (state_q),
    .hx         (hx),
    .hy         (hy),
    .play_valid (pv_q),
    .btn        (btn)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_TITLE;
      last_q  <= ST_STAGE1;
      todo_q  <= TODO_NONE;
      key_q   <= 2'd0;
      heart_q <= 2'd3;
      pv_q    <= PV_RESET;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      todo_q  <= todo_d;
      key_q   <= key_d;
      heart_q <= heart_d;
      pv_q    <= pv_d;
      cnt_q   <= cnt_d;
    end
  end

  // Door completion takes priority over damage so a simultaneous hit cannot
  // cost a life on the winning frame; todo is judged on its pre-update value.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    todo_d  = todo_q;
    key_d   = key_q;
    heart_d = heart_q;
    pv_d    = pv_q;
    cnt_d   = (cnt_q == '0) ? '0 : cnt_q - CNT_W'(1);

    if (is_stage(state_q)) begin
      if (key_pick && key_q != 2'd3) begin
        key_d = key_q + 2'd1;
        if (key_q == 2'd2) todo_d = TODO_FIND_DOOR;
      end
      if (door_enter && todo_q == TODO_FIND_DOOR) begin
        state_d = success_of(state_q);
      end else if (damage && cnt_q == '0) begin
        heart_d = heart_q - 2'd1;
        cnt_d   = CNT_LOAD;
        if (heart_q == 2'd1) state_d = ST_FAIL;
      end
    end else if (click) begin
      case (btn)
        BTN_STAGE1: state_d = ST_STAGE1;
        BTN_STAGE2: state_d = ST_STAGE2;
        BTN_STAGE3: state_d = ST_STAGE3;
        BTN_NEXT:   state_d = next_of(state_q);
        BTN_BACK:   state_d = ST_TITLE;
        BTN_RETRY:  state_d = last_q;
        BTN_ANY:    state_d = ST_TITLE;
        default:    state_d = state_q;
      endcase
    end

    if (is_stage(state_d) && !is_stage(state_q)) begin
      key_d   = 2'd0;
      heart_d = 2'd3;
      todo_d  = TODO_FIND_KEY;
      cnt_d   = '0;
      last_d  = state_d;
    end
    if (!is_stage(state_d)) todo_d = TODO_NONE;
    if (state_d == ST_SUCCESS1) pv_d[2] = 1'b1;
    if (state_d == ST_SUCCESS2) pv_d[3] = 1'b1;
  end

  assign state      = state_q;
  assign todo       = todo_q;
  assign key_find   = key_q;
  assign heart      = heart_q;
  assign play_valid = pv_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed bench for game_flow_ctrl with a short invulnerability window.
// Also builds with GAME_UNLOCK_ALL_EN defined.
module tb_game_flow_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] mouse_x, mouse_y;
  logic       click, key_pick, door_enter, damage;
  logic [3:0] state;
  logic [1:0] todo, key_find, heart;
  logic [3:0] play_valid;

  int total = 0;
  int bad   = 0;

`ifdef GAME_UNLOCK_ALL_EN
  localparam logic [3:0] PV_RST = 4'b1110;
`else
  localparam logic [3:0] PV_RST = 4'b0010;
`endif

  game_flow_ctrl #(.INVULN_CYCLES(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .mouse_x    (mouse_x),
    .mouse_y    (mouse_y),
    .click      (click),
    .key_pick   (key_pick),
    .door_enter (door_enter),
    .damage     (damage),
    .state      (state),
    .todo       (todo),
    .key_find   (key_find),
    .heart      (heart),
    .play_valid (play_valid)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    total++;
    if (observed != expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
    end
  endtask

  // One clock with the given inputs held across the edge; outputs are
  // stable for checking when the task returns.
  task automatic applyStimulus(input logic r, input logic c, input logic k,
                               input logic d, input logic g,
                               input int x, input int y);
    @(negedge clk);
    rst = r; click = c; key_pick = k; door_enter = d; damage = g;
    mouse_x = 10'(x); mouse_y = 10'(y);
    @(posedge clk);
    #1;
    rst = 1'b0; click = 1'b0; key_pick = 1'b0; door_enter = 1'b0; damage = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic clickAt(input int x, input int y);
    applyStimulus(0, 1, 0, 0, 0, x, y);
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_state"}, state, 0);
    checkOutput({tag, "_todo"}, todo, 0);
    checkOutput({tag, "_key"}, key_find, 0);
    checkOutput({tag, "_heart"}, heart, 3);
    checkOutput({tag, "_pv"}, play_valid, PV_RST);
  endtask

  task automatic finishStage(input string tag, input int succ_state);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 0, 0, 0, 0);
    checkOutput({tag, "_keys"}, key_find, 3);
    checkOutput({tag, "_todo_door"}, todo, 3);
    applyStimulus(0, 0, 0, 1, 0, 0, 0);
    checkOutput({tag, "_success"}, state, succ_state);
    checkOutput({tag, "_todo_none"}, todo, 0);
  endtask

  initial begin
    rst = 1'b0; click = 1'b0; key_pick = 1'b0; door_enter = 1'b0; damage = 1'b0;
    mouse_x = '0; mouse_y = '0;

    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    checkReset("reset");

`ifndef GAME_UNLOCK_ALL_EN
    clickAt(320, 340);
    checkOutput("locked_stage2", state, 0);
    clickAt(100, 260);
    checkOutput("miss_column", state, 0);
`endif

    clickAt(320, 260);
    checkOutput("enter_s1_state", state, 2);
    checkOutput("enter_s1_heart", heart, 3);
    checkOutput("enter_s1_todo", todo, 1);
    applyStimulus(0, 1, 0, 1, 0, 320, 380);
    checkOutput("s1_door_no_key", state, 2);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 0, 0, 0, 0);
    checkOutput("s1_key3", key_find, 3);
    checkOutput("s1_todo_door", todo, 3);
    applyStimulus(0, 0, 1, 0, 0, 0, 0);
    checkOutput("s1_key_sat", key_find, 3);
    applyStimulus(0, 0, 0, 1, 0, 0, 0);
    checkOutput("s1_success", state, 3);
    checkOutput("s1_unlock", play_valid, PV_RST | 4'b0100);
    checkOutput("s1_todo_none", todo, 0);

    clickAt(320, 380);
    checkOutput("back_title", state, 0);
    clickAt(320, 340);
    checkOutput("enter_s2", state, 4);

    applyStimulus(0, 0, 1, 0, 1, 0, 0);
    checkOutput("s2_both_key", key_find, 1);
    checkOutput("s2_both_heart", heart, 2);
    applyStimulus(0, 0, 1, 0, 0, 0, 0);
    checkOutput("s2_key2", key_find, 2);
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    checkReset("mid_reset");

    clickAt(320, 260);
    finishStage("s1b", 3);
    clickAt(320, 300);
    checkOutput("next_s2", state, 4);
    checkOutput("next_s2_heart", heart, 3);

    // Pulses at cycles 0,2,4,8,12 against a 4-cycle immunity window.
    applyStimulus(0, 0, 0, 0, 1, 0, 0);
    checkOutput("dmg_c0", heart, 2);
    idle(1);
    applyStimulus(0, 0, 0, 0, 1, 0, 0);
    checkOutput("dmg_c2_immune", heart, 2);
    idle(1);
    applyStimulus(0, 0, 0, 0, 1, 0, 0);
    checkOutput("dmg_c4", heart, 1);
    checkOutput("dmg_c4_state", state, 4);
    idle(3);
    applyStimulus(0, 0, 0, 0, 1, 0, 0);
    checkOutput("dmg_c8_heart", heart, 0);
    checkOutput("dmg_c8_fail", state, 8);
    checkOutput("fail_todo", todo, 0);
    idle(3);
    applyStimulus(0, 0, 0, 0, 1, 0, 0);
    checkOutput("dmg_c12_ignored", heart, 0);
    clickAt(320, 300);
    checkOutput("retry_state", state, 4);
    checkOutput("retry_heart", heart, 3);

    applyStimulus(0, 0, 0, 0, 1, 0, 0);
    idle(3);
    applyStimulus(0, 0, 0, 0, 1, 0, 0);
    checkOutput("s2_heart1", heart, 1);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 0, 0, 0, 0);
    idle(3);
    applyStimulus(0, 0, 0, 1, 1, 0, 0);
    checkOutput("door_dmg_state", state, 5);
    checkOutput("door_dmg_heart", heart, 1);
    checkOutput("s2_unlock", play_valid, 4'b1110);

    clickAt(320, 300);
    checkOutput("next_s3", state, 6);
    applyStimulus(0, 0, 1, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 1, 0, 0, 0);
    checkOutput("key3_door_state", state, 6);
    checkOutput("key3_door_todo", todo, 3);
    applyStimulus(0, 0, 0, 1, 0, 0, 0);
    checkOutput("s3_success", state, 7);
    clickAt(320, 380);
    checkOutput("s3_no_back", state, 7);
    clickAt(320, 300);
    checkOutput("to_staff", state, 1);
    clickAt(5, 7);
    checkOutput("staff_title", state, 0);
    clickAt(320, 420);
    checkOutput("title_s3", state, 6);

    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    checkReset("final_reset");
`ifdef GAME_UNLOCK_ALL_EN
    clickAt(320, 420);
    checkOutput("unlock_all_s3", state, 6);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
